cacheline_bmem_arbiter: RTL and testbench



---
 rtl/cacheline_bmem_arbiter.sv | 124 ++++++++++++
 tb/tb_cacheline_bmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_bmem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port, splitting
// each line into NUM_BEATS beats and reassembling read beats into a full line.
module cacheline_bmem_arbiter #(
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned NUM_BEATS = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  input  logic              imem_read,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [31:0]       dmem_addr,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic [31:0]       bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  input  logic [BEAT_W-1:0] bmem_rdata,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_resp
);

  localparam int unsigned CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat;
  logic              last_grant_d;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rbuf;
  logic [LINE_W-1:0] rline_next;
  logic              last_beat;
  logic              d_pending;
  logic              grant_d;
  logic              grant_i;
  logic [31:0]       grant_addr;

  // Round-robin on a tie: dcache wins unless it was the last one granted.
  assign d_pending  = dmem_read | dmem_write;
  assign grant_d    = d_pending & (~imem_read | ~last_grant_d);
  assign grant_i    = imem_read & ~grant_d;
  assign grant_addr = grant_d ? dmem_addr : imem_addr;
  assign last_beat  = (beat == CNT_W'(NUM_BEATS - 1));

  always_comb begin
    rline_next = rbuf;
    rline_next[beat*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  assign bmem_read  = (state == RD_I) || (state == RD_D);
  assign bmem_write = (state == WR_D);
  assign bmem_wdata = bmem_write ? wline[beat*BEAT_W +: BEAT_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      last_grant_d <= 1'b0;
      bmem_address <= '0;
      wline        <= '0;
      rbuf         <= '0;
      imem_rdata   <= '0;
      dmem_rdata   <= '0;
      imem_resp    <= 1'b0;
      dmem_resp    <= 1'b0;
    end else begin
      imem_resp <= 1'b0;
      dmem_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            bmem_address <= grant_addr & ~32'h1F;
            beat         <= '0;
            last_grant_d <= grant_d;
          end
          if (grant_d) begin
            if (dmem_write) begin
              wline <= dmem_wdata;
              state <= WR_D;
            end else begin
              state <= RD_D;
            end
          end else if (grant_i) begin
            state <= RD_I;
          end
        end
        RD_I, RD_D: begin
          if (bmem_resp) begin
            rbuf <= rline_next;
            beat <= beat + 1'b1;
            if (last_beat) begin
              state <= RESP;
              if (state == RD_I) begin
                imem_rdata <= rline_next;
                imem_resp  <= 1'b1;
              end else begin
                dmem_rdata <= rline_next;
                dmem_resp  <= 1'b1;
              end
            end
          end
        end
        WR_D: begin
          if (bmem_resp) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state     <= RESP;
              dmem_resp <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_bmem_arbiter.sv
// Directed + randomized bench for cacheline_bmem_arbiter with a burst memory
// responder and a transaction-level arbitration/line model.
module tb_cacheline_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  imem_addr;
  logic         imem_read;
  logic [255:0] imem_rdata;
  logic         imem_resp;
  logic [31:0]  dmem_addr;
  logic         dmem_read;
  logic         dmem_write;
  logic [255:0] dmem_wdata;
  logic [255:0] dmem_rdata;
  logic         dmem_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_rdata;
  logic [63:0]  bmem_wdata;
  logic         bmem_resp;

  always #5 clk = ~clk;

  cacheline_bmem_arbiter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp)
  );

  int unsigned  tests = 0;
  int unsigned  fails = 0;
  bit           last_i;        // model: icache was the most recent grant
  logic [255:0] exp_irdata;
  logic [255:0] exp_drdata;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_bmem_rw"}, {bmem_read, bmem_write}, '0);
    check({tag, "_bmem_address"}, bmem_address, '0);
    check({tag, "_bmem_wdata"}, bmem_wdata, '0);
    check({tag, "_resps"}, {imem_resp, dmem_resp}, '0);
    check({tag, "_imem_rdata"}, imem_rdata, '0);
    check({tag, "_dmem_rdata"}, dmem_rdata, '0);
  endtask

  // Memory side of one granted line transfer, plus the requester's view of resp.
  task automatic serve(input bit src_d, input bit is_wr, input logic [31:0] addr,
                       input logic [255:0] wl, input int unsigned waits, input bit fixed);
    int unsigned  n;
    logic [255:0] line;
    logic [63:0]  beatv;
    logic [3:0]   nib;
    n = 0;
    @(negedge clk);
    while (!(bmem_read || bmem_write) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("grant_latency", 256'(n), 256'(0));
    check("bmem_rw", {bmem_read, bmem_write}, {!is_wr, is_wr});
    check("bmem_address", bmem_address, {addr[31:5], 5'b0});
    line = '0;
    for (int k = 0; k < 4; k++) begin
      for (int unsigned w = 0; w < waits; w++) begin
        check("hold_address", bmem_address, {addr[31:5], 5'b0});
        check("hold_rw", {bmem_read, bmem_write}, {!is_wr, is_wr});
        if (is_wr) check("hold_wdata", bmem_wdata, wl[64*k +: 64]);
        @(negedge clk);
      end
      if (is_wr) check("bmem_wdata", bmem_wdata, wl[64*k +: 64]);
      check("early_resp", {imem_resp, dmem_resp}, '0);
      nib = 4'(k + 1);
      beatv = fixed ? {16{nib}} : {$urandom, $urandom};
      line[64*k +: 64] = beatv;
      bmem_rdata = beatv;
      bmem_resp  = 1'b1;
      @(negedge clk);
      bmem_resp  = 1'b0;
      bmem_rdata = {$urandom, $urandom};
    end
    check("imem_resp", imem_resp, !src_d);
    check("dmem_resp", dmem_resp, src_d);
    check("rw_in_resp", {bmem_read, bmem_write}, '0);
    if (!is_wr) begin
      if (src_d) exp_drdata = line;
      else       exp_irdata = line;
    end
    check("imem_rdata", imem_rdata, exp_irdata);
    check("dmem_rdata", dmem_rdata, exp_drdata);
    if (src_d) begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
    end else begin
      imem_read = 1'b0;
    end
    last_i = !src_d;
    @(negedge clk);
    check("resp_one_cycle", {imem_resp, dmem_resp}, '0);
    check("imem_rdata_hold", imem_rdata, exp_irdata);
    check("dmem_rdata_hold", dmem_rdata, exp_drdata);
  endtask

  // Issue requests in the current (idle) cycle; the model decides the order of service.
  task automatic txn(input bit ireq, input bit drd, input bit dwr, input logic [31:0] ia,
                     input logic [31:0] da, input logic [255:0] wd, input int unsigned waits,
                     input bit fixed);
    bit dreq;
    bit first_d;
    dreq       = drd | dwr;
    imem_addr  = ia;
    dmem_addr  = da;
    dmem_wdata = wd;
    imem_read  = ireq;
    dmem_read  = drd;
    dmem_write = dwr;
    first_d    = dreq && (!ireq || last_i);
    if (first_d) serve(1'b1, dwr, da, wd, waits, fixed);
    else         serve(1'b0, 1'b0, ia, wd, waits, fixed);
    if (ireq && dreq) begin
      if (first_d) serve(1'b0, 1'b0, ia, wd, waits, fixed);
      else         serve(1'b1, dwr, da, wd, waits, fixed);
    end
  endtask

  initial begin
    logic [255:0] wd;
    int unsigned  pat;
    rst = 1'b1;
    imem_addr = '0; imem_read = 1'b0;
    dmem_addr = '0; dmem_read = 1'b0; dmem_write = 1'b0; dmem_wdata = '0;
    bmem_rdata = '0; bmem_resp = 1'b0;
    last_i = 1'b1; exp_irdata = '0; exp_drdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Both caches requesting straight out of reset: dcache first.
    rst = 1'b0;
    txn(1'b1, 1'b1, 1'b0, 32'h4000_0044, 32'h5000_0013, '0, 0, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h4000_1000, 32'h5000_2000, '0, 1, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h5000_3000, 32'h5000_3000, '0, 0, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h4000_4000, 32'h5000_5000, '0, 0, 1'b0);

    txn(1'b1, 1'b0, 1'b0, 32'h6000_0024, 32'h0, '0, 0, 1'b1);
    check("plan_icache_line", imem_rdata,
          {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    wd = rand_line();
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h6000_1000, wd, 0, 1'b0);

    txn(1'b1, 1'b0, 1'b0, 32'h6000_2040, 32'h0, '0, 3, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h6000_3060, rand_line(), 3, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h6000_4088, '0, 3, 1'b0);

    // Illegal read+write together: write wins.
    txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h6000_5000, rand_line(), 0, 1'b0);

    // Stray beat responses while idle.
    bmem_resp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_rw", {bmem_read, bmem_write}, '0);
      check("stray_resp", {imem_resp, dmem_resp}, '0);
    end
    bmem_resp = 1'b0;
    txn(1'b1, 1'b0, 1'b0, 32'h6000_6000, 32'h0, '0, 0, 1'b0);

    // Reset after two read beats abandons the burst.
    imem_addr = 32'h6000_7000;
    imem_read = 1'b1;
    @(negedge clk);
    check("mid_burst_read", bmem_read, 1'b1);
    for (int k = 0; k < 2; k++) begin
      bmem_rdata = {$urandom, $urandom};
      bmem_resp  = 1'b1;
      @(negedge clk);
    end
    bmem_resp = 1'b0;
    rst = 1'b1;
    imem_read = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    last_i = 1'b1; exp_irdata = '0; exp_drdata = '0;
    txn(1'b1, 1'b0, 1'b0, 32'h6000_8000, 32'h0, '0, 0, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 32'h6000_9000, 32'h6000_A000, '0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      pat = $urandom_range(0, 5);
      case (pat)
        0:       txn(1'b1, 1'b0, 1'b0, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
        1:       txn(1'b0, 1'b1, 1'b0, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
        2:       txn(1'b0, 1'b0, 1'b1, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
        3:       txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
        4:       txn(1'b1, 1'b0, 1'b1, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
        default: txn(1'b1, 1'b1, 1'b1, $urandom, $urandom, rand_line(), $urandom_range(0, 3), 1'b0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
